// File: rtl/select_action_eps.sv
// Epsilon-greedy action selector for the per-node routing agent.
// Picks sink / random neighbour / next hop / self, then logs it to memory.
module select_action_eps #(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    IDX_WIDTH   = 3,
  parameter int                    EPS_WIDTH   = 8,
  parameter int                    EPSILON     = 26,
  parameter int                    NULL_ID     = 65,
  parameter logic [WORD_WIDTH-1:0] FLAG_ADDR   = 16'h0002,
  parameter logic [WORD_WIDTH-1:0] ACTION_ADDR = 16'h07FE,
  parameter logic [WORD_WIDTH-1:0] NBR_BASE    = 16'h0010
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  explore_en,
  input  logic [WORD_WIDTH-1:0] nexthop,
  input  logic [WORD_WIDTH-1:0] nextsink,
  input  logic [WORD_WIDTH-1:0] rng_in,
  input  logic [IDX_WIDTH:0]    nbr_count,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic [WORD_WIDTH-1:0] action,
  output logic                  for_aggregation,
  output logic                  explored,
  output logic                  done
);

  localparam int CW = IDX_WIDTH + 1;
  localparam int PW = 2 * IDX_WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(1 << IDX_WIDTH);
  localparam logic [WORD_WIDTH-1:0] NULL_W = WORD_WIDTH'(NULL_ID);
  localparam logic [EPS_WIDTH-1:0] EPS_W = EPS_WIDTH'(EPSILON);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_RD_NBR,
    S_WAIT_NBR,
    S_WR_FLAG,
    S_WR_ACTION,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WORD_WIDTH-1:0] nexthop_q, nexthop_d;
  logic [WORD_WIDTH-1:0] nextsink_q, nextsink_d;
  logic [EPS_WIDTH-1:0]  eps_q, eps_d;
  logic [IDX_WIDTH-1:0]  ridx_q, ridx_d;
  logic                  explore_q, explore_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [WORD_WIDTH-1:0] address_q, address_d;
  logic                  wr_en_q, wr_en_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic [WORD_WIDTH-1:0] action_q, action_d;
  logic                  agg_q, agg_d;
  logic                  explored_q, explored_d;
  logic                  done_q, done_d;

  logic [CW-1:0]         cnt_sat;
  logic [PW-1:0]         prod;
  logic [CW-1:0]         idx;
  logic [WORD_WIDTH-1:0] nbr_addr;
  logic                  explore_go;
  logic                  to_flag;

  assign cnt_sat = (nbr_count > CNT_MAX) ? CNT_MAX : nbr_count;

  // Scaling by count keeps the chosen index strictly below count.
  assign prod     = PW'(ridx_q) * PW'(cnt_q);
  assign idx      = prod[PW-1:IDX_WIDTH];
  assign nbr_addr = NBR_BASE + WORD_WIDTH'(idx);

  assign explore_go = explore_q && (eps_q < EPS_W) && (cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    nexthop_d  = nexthop_q;
    nextsink_d = nextsink_q;
    eps_d      = eps_q;
    ridx_d     = ridx_q;
    explore_d  = explore_q;
    cnt_d      = cnt_q;
    address_d  = address_q;
    wr_en_d    = 1'b0;
    data_out_d = data_out_q;
    action_d   = action_q;
    agg_d      = agg_q;
    explored_d = explored_q;
    done_d     = 1'b0;
    to_flag    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nexthop_d  = nexthop;
          nextsink_d = nextsink;
          eps_d      = rng_in[WORD_WIDTH-1 -: EPS_WIDTH];
          ridx_d     = rng_in[IDX_WIDTH-1:0];
          explore_d  = explore_en;
          cnt_d      = cnt_sat;
          state_d    = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (nextsink_q != NULL_W) begin
          action_d   = nextsink_q;
          agg_d      = 1'b0;
          explored_d = 1'b0;
          to_flag    = 1'b1;
        end else if (explore_go) begin
          address_d = nbr_addr;
          state_d   = S_RD_NBR;
        end else begin
          action_d   = (nexthop_q != NULL_W) ? nexthop_q : NULL_W;
          agg_d      = (nexthop_q == NULL_W);
          explored_d = 1'b0;
          to_flag    = 1'b1;
        end
      end
      S_RD_NBR: state_d = S_WAIT_NBR;
      S_WAIT_NBR: begin
        to_flag = 1'b1;
        if (data_in != NULL_W) begin
          action_d   = data_in;
          agg_d      = 1'b0;
          explored_d = 1'b1;
        end else begin
          action_d   = (nexthop_q != NULL_W) ? nexthop_q : NULL_W;
          agg_d      = (nexthop_q == NULL_W);
          explored_d = 1'b0;
        end
      end
      S_WR_FLAG: begin
        wr_en_d    = 1'b1;
        address_d  = ACTION_ADDR;
        data_out_d = action_q;
        state_d    = S_WR_ACTION;
      end
      S_WR_ACTION: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (to_flag) begin
      wr_en_d    = 1'b1;
      address_d  = FLAG_ADDR;
      data_out_d = WORD_WIDTH'(agg_d);
      state_d    = S_WR_FLAG;
    end
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      nexthop_q  <= NULL_W;
      nextsink_q <= NULL_W;
      eps_q      <= '0;
      ridx_q     <= '0;
      explore_q  <= 1'b0;
      cnt_q      <= '0;
      address_q  <= '0;
      wr_en_q    <= 1'b0;
      data_out_q <= '0;
      action_q   <= NULL_W;
      agg_q      <= 1'b0;
      explored_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nexthop_q  <= nexthop_d;
      nextsink_q <= nextsink_d;
      eps_q      <= eps_d;
      ridx_q     <= ridx_d;
      explore_q  <= explore_d;
      cnt_q      <= cnt_d;
      address_q  <= address_d;
      wr_en_q    <= wr_en_d;
      data_out_q <= data_out_d;
      action_q   <= action_d;
      agg_q      <= agg_d;
      explored_q <= explored_d;
      done_q     <= done_d;
    end
  end

  assign address         = address_q;
  assign wr_en           = wr_en_q;
  assign data_out        = data_out_q;
  assign action          = action_q;
  assign for_aggregation = agg_q;
  assign explored        = explored_q;
  assign done            = done_q;

endmodule

// File: tb/tb_select_action_eps.sv
// Directed bench for select_action_eps.
// Checks decisions, memory writes, latency and reset behaviour.
module tb_select_action_eps;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic        explore_en;
  logic [15:0] nexthop;
  logic [15:0] nextsink;
  logic [15:0] rng_in;
  logic [3:0]  nbr_count;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic [15:0] action;
  logic        for_aggregation;
  logic        explored;
  logic        done;

  select_action_eps dut (
    .clock          (clock),
    .nrst           (nrst),
    .start          (start),
    .explore_en     (explore_en),
    .nexthop        (nexthop),
    .nextsink       (nextsink),
    .rng_in         (rng_in),
    .nbr_count      (nbr_count),
    .data_in        (data_in),
    .address        (address),
    .wr_en          (wr_en),
    .data_out       (data_out),
    .action         (action),
    .for_aggregation(for_aggregation),
    .explored       (explored),
    .done           (done)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  int          wr_n;
  int          wr_cyc0;
  int          done_n;
  int          done_cyc;
  logic [15:0] wa [2];
  logic [15:0] wd [2];
  logic [15:0] rd_addr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transaction; cycle 1 is the cycle right after the start edge.
  task automatic run(input logic [15:0] sink, input logic [15:0] hop,
                     input logic [15:0] rng, input logic [15:0] din,
                     input logic ex, input logic [3:0] cnt,
                     input bit poke);
    @(negedge clock);
    nextsink   = sink;
    nexthop    = hop;
    rng_in     = rng;
    data_in    = din;
    explore_en = ex;
    nbr_count  = cnt;
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wr_n     = 0;
    wr_cyc0  = 0;
    done_n   = 0;
    done_cyc = 0;
    rd_addr  = '0;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin
        @(posedge clock);
        #1 start = 1'b0;
      end
      if (c == 2) rd_addr = address;
      if (wr_en) begin
        if (wr_n < 2) begin
          wa[wr_n] = address;
          wd[wr_n] = data_out;
        end
        if (wr_n == 0) wr_cyc0 = c;
        wr_n++;
      end
      if (done) begin
        if (done_n == 0) done_cyc = c;
        done_n++;
      end
      if (c == 1 && poke) start = 1'b1;
    end
  endtask

  initial begin
    nrst       = 1'b0;
    start      = 1'b0;
    explore_en = 1'b0;
    nexthop    = 16'd65;
    nextsink   = 16'd65;
    rng_in     = '0;
    nbr_count  = '0;
    data_in    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_action", action, 16'd65);
    check("rst_agg", for_aggregation, 1'b0);
    check("rst_expl", explored, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_addr", address, 16'h0000);
    check("rst_dout", data_out, 16'h0000);
    @(negedge clock);
    nrst = 1'b1;

    // sink wins over next hop
    run(16'd12, 16'd7, 16'h0000, 16'd0, 1'b0, 4'd0, 1'b0);
    check("t1_action", action, 16'd12);
    check("t1_expl", explored, 1'b0);
    check("t1_agg", for_aggregation, 1'b0);
    check("t1_wr_n", wr_n, 2);
    check("t1_wr_cyc", wr_cyc0, 2);
    check("t1_wa0", wa[0], 16'h0002);
    check("t1_wd0", wd[0], 16'd0);
    check("t1_wa1", wa[1], 16'h07FE);
    check("t1_wd1", wd[1], 16'd12);
    check("t1_done_cyc", done_cyc, 4);
    check("t1_done_n", done_n, 1);

    // no sink, no hop: self with aggregation
    run(16'd65, 16'd65, 16'h0000, 16'd0, 1'b0, 4'd4, 1'b0);
    check("t2_action", action, 16'd65);
    check("t2_agg", for_aggregation, 1'b1);
    check("t2_wd0", wd[0], 16'd1);
    check("t2_wd1", wd[1], 16'd65);
    check("t2_done_cyc", done_cyc, 4);

    // explore: idx = (5*4)>>3 = 2
    run(16'd65, 16'd7, 16'h0005, 16'd33, 1'b1, 4'd4, 1'b0);
    check("t3_rd_addr", rd_addr, 16'h0012);
    check("t3_action", action, 16'd33);
    check("t3_expl", explored, 1'b1);
    check("t3_agg", for_aggregation, 1'b0);
    check("t3_wr_cyc", wr_cyc0, 4);
    check("t3_wd0", wd[0], 16'd0);
    check("t3_wa1", wa[1], 16'h07FE);
    check("t3_wd1", wd[1], 16'd33);
    check("t3_done_cyc", done_cyc, 6);

    // explore reads NULL entry: fall back to next hop
    run(16'd65, 16'd7, 16'h0005, 16'd65, 1'b1, 4'd4, 1'b0);
    check("t4_rd_addr", rd_addr, 16'h0012);
    check("t4_action", action, 16'd7);
    check("t4_expl", explored, 1'b0);
    check("t4_done_cyc", done_cyc, 6);

    // empty neighbour table: no read
    run(16'd65, 16'd7, 16'h0000, 16'd50, 1'b1, 4'd0, 1'b0);
    check("t5_action", action, 16'd7);
    check("t5_done_cyc", done_cyc, 4);
    check("t5_wr_cyc", wr_cyc0, 2);

    // random field 255 above threshold: no explore
    run(16'd65, 16'd9, 16'hFF05, 16'd33, 1'b1, 4'd4, 1'b0);
    check("t6_action", action, 16'd9);
    check("t6_expl", explored, 1'b0);
    check("t6_done_cyc", done_cyc, 4);

    // count 15 saturates to 8: idx = (7*8)>>3 = 7
    run(16'd65, 16'd7, 16'h0007, 16'd40, 1'b1, 4'd15, 1'b0);
    check("t7_rd_addr", rd_addr, 16'h0017);
    check("t7_action", action, 16'd40);
    check("t7_expl", explored, 1'b1);

    // reset taken at the edge that would enter the flag write
    @(negedge clock);
    nextsink   = 16'd12;
    nexthop    = 16'd7;
    explore_en = 1'b0;
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    nrst = 1'b0;
    @(posedge clock);
    #1;
    check("r_wr_en", wr_en, 1'b0);
    check("r_action", action, 16'd65);
    check("r_expl", explored, 1'b0);
    check("r_addr", address, 16'h0000);
    check("r_done", done, 1'b0);
    @(negedge clock);
    nrst = 1'b1;
    @(posedge clock);
    #1;
    check("r_no_pending", wr_en, 1'b0);

    // start poked during DECIDE must not queue a second run
    run(16'd65, 16'd5, 16'h0000, 16'd0, 1'b0, 4'd0, 1'b1);
    check("p_action", action, 16'd5);
    check("p_done_cyc", done_cyc, 4);
    check("p_done_n", done_n, 1);
    check("p_wr_n", wr_n, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
